// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry. It also resolves branches in the execute stage and counts
// mispredictions.
//
// The fetch side looks up the table combinationally from if_pc and returns
// the predicted next fetch PC. The execute side computes the real next PC
// from the resolving instruction and compares it with the PC that was
// predicted for it. On a mismatch it raises br_taken_cancel. The table is
// trained on the following clock edge.
//
// Parameters
//   ENTRIES  number of table entries (power of two, 2..256)
//   PRED_EN  1 = dynamic prediction, 0 = always predict fall-through
//
// Ports
//   clk, reset        clock and asynchronous active-high reset
//   if_valid, if_pc   fetch-stage lookup request
//   pred_pc           predicted next fetch PC
//   pred_taken        table hit with a taken-leaning counter
//   ex_valid          resolving instruction is valid
//   ex_is_branch      resolving instruction is a branch/jump
//   ex_cond           branch condition (1 for unconditional branches)
//   ex_pc             PC of the resolving instruction
//   ex_pred_pc        prediction that travelled with the instruction
//   ex_src1, ex_src2  operands whose sum is the branch target
//   next_PC           resolved next PC
//   br_taken_cancel   misprediction: flush and refetch from next_PC
//   mispred_cnt       running count of mispredictions
// ---------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int PRED_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_cond,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pred_pc,
    input  logic [31:0] ex_src1,
    input  logic [31:0] ex_src2,
    output logic [31:0] next_PC,
    output logic        br_taken_cancel,
    output logic [31:0] mispred_cnt
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = 30 - IDX;

    // Table storage, one slot per index.
    logic           valid_q  [ENTRIES];
    logic [TAG-1:0] tag_q    [ENTRIES];
    logic [31:0]    target_q [ENTRIES];
    logic [1:0]     ctr_q    [ENTRIES];

    logic [IDX-1:0] if_idx;
    logic [TAG-1:0] if_tag;
    logic           if_hit;

    logic [IDX-1:0] ex_idx;
    logic [TAG-1:0] ex_tag;
    logic           ex_hit;
    logic           ex_taken;
    logic [31:0]    ex_target;
    logic           do_update;

    // Fetch-side lookup. The table reads its registered contents directly.
    // A same-cycle update is therefore visible only from the next cycle.
    // Reset gates the hit so the fall-through path is used while reset is
    // held.
    always_comb begin
        if_idx     = if_pc[IDX+1:2];
        if_tag     = if_pc[31:IDX+2];
        if_hit     = if_valid & ~reset & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
        pred_taken = if_hit & ctr_q[if_idx][1];
        pred_pc    = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);
    end

    // Execute-side resolution. The resolved PC is compared with the PC the
    // front end actually fetched for this instruction. Any difference is a
    // misprediction, whatever the reason.
    always_comb begin
        ex_idx          = ex_pc[IDX+1:2];
        ex_tag          = ex_pc[31:IDX+2];
        ex_hit          = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
        ex_taken        = ex_is_branch & ex_cond;
        ex_target       = ex_src1 + ex_src2;
        next_PC         = 32'd0;
        br_taken_cancel = 1'b0;
        if (!reset) begin
            next_PC         = ex_taken ? ex_target : (ex_pc + 32'd4);
            br_taken_cancel = ex_valid & ex_is_branch & (ex_pred_pc != next_PC);
        end
        do_update = (PRED_EN != 0) & ex_valid & ex_is_branch;
    end

    // Table training. A hit nudges the counter toward the resolved direction.
    // A taken hit also refreshes the target in case it moved, e.g. for jirl.
    // A taken miss steals the slot and starts it at weakly-taken.
    // A not-taken miss changes nothing.
    // With PRED_EN = 0, do_update is constant 0, so the table stays in its
    // reset state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (do_update) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                    end
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    // Misprediction counter. It wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispred_cnt <= 32'd0;
        end else if (br_taken_cancel) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Two predictors share one stimulus stream:
//   dut_a  ENTRIES = 4, dynamic prediction
//   dut_s  ENTRIES = 16, static fall-through
//
// Each applied cycle pushes its expected outputs into a scoreboard queue.
// The expected outputs come from a behavioural model that holds the table
// as plain arrays. An independent monitor pops the queue each cycle and
// compares the entry with what the DUTs present.
// ---------------------------------------------------------------------------
module tb_branch_target_predictor;

    localparam int EA = 4;
    localparam int IA = $clog2(EA);

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_cond;
    logic [31:0] ex_pc;
    logic [31:0] ex_pred_pc;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;

    logic [31:0] pred_pc_a, next_pc_a, cnt_a;
    logic        pred_taken_a, cancel_a;
    logic [31:0] pred_pc_s, next_pc_s, cnt_s;
    logic        pred_taken_s, cancel_s;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pred_pc_a;
        logic        pred_taken_a;
        logic [31:0] next_pc;
        logic        cancel;
        logic [31:0] cnt_a;
        logic [31:0] pred_pc_s;
        logic        pred_taken_s;
        logic [31:0] cnt_s;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state for the dynamic predictor.
    bit          m_valid [EA];
    logic [31:0] m_tag   [EA];
    logic [31:0] m_tgt   [EA];
    int          m_ctr   [EA];
    logic [31:0] m_cnt_a;
    logic [31:0] m_cnt_s;

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(EA), .PRED_EN(1)) dut_a (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_pc(pred_pc_a), .pred_taken(pred_taken_a),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
        .ex_pc(ex_pc), .ex_pred_pc(ex_pred_pc),
        .ex_src1(ex_src1), .ex_src2(ex_src2),
        .next_PC(next_pc_a), .br_taken_cancel(cancel_a), .mispred_cnt(cnt_a)
    );

    branch_target_predictor #(.ENTRIES(16), .PRED_EN(0)) dut_s (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_pc(pred_pc_s), .pred_taken(pred_taken_s),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
        .ex_pc(ex_pc), .ex_pred_pc(ex_pred_pc),
        .ex_src1(ex_src1), .ex_src2(ex_src2),
        .next_PC(next_pc_s), .br_taken_cancel(cancel_s), .mispred_cnt(cnt_s)
    );

    // One comparison: count it and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, predict the outputs,
    // queue them, then advance the model past the next rising edge.
    task automatic applyStimulus(
        input logic        rst_i,
        input logic        ifv,
        input logic [31:0] ifpc,
        input logic        exv,
        input logic        isb,
        input logic        cond,
        input logic [31:0] expc,
        input logic [31:0] expred,
        input logic [31:0] s1,
        input logic [31:0] s2
    );
        exp_t        e;
        int          i;
        bit          hit;
        bit          taken;
        logic [31:0] npc;
        logic [31:0] tgt;
        @(negedge clk);
        reset        = rst_i;
        if_valid     = ifv;
        if_pc        = ifpc;
        ex_valid     = exv;
        ex_is_branch = isb;
        ex_cond      = cond;
        ex_pc        = expc;
        ex_pred_pc   = expred;
        ex_src1      = s1;
        ex_src2      = s2;

        if (rst_i) begin
            for (int k = 0; k < EA; k++) begin
                m_valid[k] = 0;
                m_tag[k]   = 0;
                m_tgt[k]   = 0;
                m_ctr[k]   = 1;
            end
            m_cnt_a = 0;
            m_cnt_s = 0;
        end

        tgt   = s1 + s2;
        taken = isb && cond;
        npc   = taken ? tgt : expc + 32'd4;

        i   = int'((ifpc >> 2) % EA);
        hit = !rst_i && ifv && m_valid[i] && (m_tag[i] == (ifpc >> (IA + 2)));
        e.pred_taken_a = hit && (m_ctr[i] >= 2);
        e.pred_pc_a    = e.pred_taken_a ? m_tgt[i] : ifpc + 32'd4;
        e.pred_pc_s    = ifpc + 32'd4;
        e.pred_taken_s = 1'b0;
        e.next_pc      = rst_i ? 32'd0 : npc;
        e.cancel       = !rst_i && exv && isb && (expred != npc);
        e.cnt_a        = m_cnt_a;
        e.cnt_s        = m_cnt_s;
        sb_q.push_back(e);

        if (!rst_i) begin
            if (e.cancel) begin
                m_cnt_a = m_cnt_a + 1;
                m_cnt_s = m_cnt_s + 1;
            end
            if (exv && isb) begin
                i = int'((expc >> 2) % EA);
                if (m_valid[i] && m_tag[i] == (expc >> (IA + 2))) begin
                    if (taken) begin
                        m_tgt[i] = tgt;
                        if (m_ctr[i] < 3) m_ctr[i]++;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end else if (taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = expc >> (IA + 2);
                    m_tgt[i]   = tgt;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    // Monitor: a few ns after each falling edge, the outputs have settled for
    // the cycle just driven. Pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("a.pred_pc",    pred_pc_a,           e.pred_pc_a);
                checkOutput("a.pred_taken", {31'd0, pred_taken_a}, {31'd0, e.pred_taken_a});
                checkOutput("a.next_PC",    next_pc_a,           e.next_pc);
                checkOutput("a.cancel",     {31'd0, cancel_a},   {31'd0, e.cancel});
                checkOutput("a.mispred_cnt", cnt_a,              e.cnt_a);
                checkOutput("s.pred_pc",    pred_pc_s,           e.pred_pc_s);
                checkOutput("s.pred_taken", {31'd0, pred_taken_s}, {31'd0, e.pred_taken_s});
                checkOutput("s.next_PC",    next_pc_s,           e.next_pc);
                checkOutput("s.cancel",     {31'd0, cancel_s},   {31'd0, e.cancel});
                checkOutput("s.mispred_cnt", cnt_s,              e.cnt_s);
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized run over a small
    // PC pool so that entries are hit, evicted and retrained often.
    initial begin
        logic [31:0] p;
        logic [31:0] q;
        reset = 1'b1; if_valid = 0; if_pc = 0; ex_valid = 0; ex_is_branch = 0;
        ex_cond = 0; ex_pc = 0; ex_pred_pc = 0; ex_src1 = 0; ex_src2 = 0;

        // Reset state, with a taken branch presented during reset.
        applyStimulus(1, 1, 32'h1C00_0000, 1, 1, 1, 32'h1C00_0010, 32'h0, 32'h1C00_0010, 32'h40);
        applyStimulus(1, 1, 32'h1C00_0010, 1, 1, 1, 32'h1C00_0010, 32'h0, 32'h1C00_0010, 32'h40);

        // Cold lookup, then an unconditional branch that mispredicts.
        applyStimulus(0, 1, 32'h1C00_0000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(0, 1, 32'h1C00_0000, 1, 1, 1, 32'h1C00_0010, 32'h1C00_0014, 32'h1C00_0010, 32'h40);
        applyStimulus(0, 1, 32'h1C00_0010, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        // if_valid low forces fall-through even on a trained PC.
        applyStimulus(0, 0, 32'h1C00_0010, 1, 0, 1, 32'h1C00_0030, 32'h0, 32'h5, 32'h6);

        // Conditional branch: allocate, then not-taken twice, then a third
        // not-taken with a correct fall-through prediction.
        p = 32'h1C00_0024;
        applyStimulus(0, 1, p, 1, 1, 1, p, p + 4, p, 32'h20);
        applyStimulus(0, 1, p, 1, 1, 0, p, p + 32'h20, p, 32'h20);
        applyStimulus(0, 1, p, 1, 1, 0, p, p + 4, p, 32'h20);
        applyStimulus(0, 1, p, 1, 1, 0, p, p + 4, p, 32'h20);
        applyStimulus(0, 1, p, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Aliasing: 0x100 and 0x110 share a slot in a 4-entry table.
        applyStimulus(0, 0, 32'h0, 1, 1, 1, 32'h100, 32'h104, 32'h100, 32'h80);
        applyStimulus(0, 1, 32'h100, 1, 1, 1, 32'h110, 32'h114, 32'h110, 32'h90);
        applyStimulus(0, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(0, 1, 32'h110, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Lookup and update of index 3 in the same cycle return the old
        // target. A reset pulse then clears everything at once.
        q = 32'h10C;
        applyStimulus(0, 0, 32'h0, 1, 1, 1, q, q + 4, 32'h200, 32'h0);
        applyStimulus(0, 1, q, 1, 1, 1, q, 32'h200, 32'h300, 32'h0);
        applyStimulus(0, 1, q, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1, 1, q, 1, 1, 1, q, q + 4, 32'h400, 32'h0);
        applyStimulus(0, 1, q, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic        r, ifv, exv, isb, cond;
            logic [31:0] ipc, epc, s1, s2, epred;
            r    = ($urandom_range(0, 199) == 0);
            ifv  = ($urandom_range(0, 4) != 0);
            exv  = ($urandom_range(0, 3) != 0);
            isb  = ($urandom_range(0, 4) != 0);
            cond = $urandom_range(0, 1);
            ipc  = 32'h1C00_0000 + 32'(4 * $urandom_range(0, 11));
            epc  = 32'h1C00_0000 + 32'(4 * $urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) begin
                s1 = $urandom;
                s2 = $urandom;
            end else begin
                s1 = epc;
                s2 = 32'(4 * $urandom_range(0, 7));
            end
            case ($urandom_range(0, 2))
                0:       epred = epc + 4;
                1:       epred = s1 + s2;
                default: epred = $urandom;
            endcase
            applyStimulus(r, ifv, ipc, exv, isb, cond, epc, epred, s1, s2);
        end

        // Let the monitor drain, bounded.
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor table entries; power of two, 2..256.
REQ-002 Parameter PRED_EN, default 1, 1 = dynamic prediction, 0 = static fall-through (pred_pc = if_pc+4, table never written).
REQ-003 Derived IDX = log2(ENTRIES); TAG = 30-IDX.
REQ-004 clk  input  1  the single clock; all state rises on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_valid  input  1  fetch PC valid this cycle.
REQ-007 if_pc  input  32  fetch-stage PC, word aligned.
REQ-008 pred_pc  output  32  predicted next fetch PC.
REQ-009 pred_taken  output  1  table hit with counter >= 2'b10.
REQ-010 ex_valid  input  1  resolve-stage instruction valid.
REQ-011 ex_is_branch  input  1  resolving instruction is jirl/b/beq/bne/bl.
REQ-012 ex_cond  input  1  branch condition true; tied 1 for unconditional branches.
REQ-013 ex_pc  input  32  PC of resolving instruction.
REQ-014 ex_pred_pc  input  32  pred_pc carried down the pipe with that instruction.
REQ-015 ex_src1, ex_src2  input  32 each  target operands; target = ex_src1 + ex_src2.
REQ-016 next_PC  output  32  resolved next PC.
REQ-017 br_taken_cancel  output  1  misprediction; flush younger instructions and refetch next_PC.
REQ-018 mispred_cnt  output  32  count of misprediction events.

Function
REQ-019 Table entry: valid bit, TAG-bit tag (pc[31:IDX+2]), 32-bit target, 2-bit saturating counter; index = pc[IDX+1:2].
REQ-020 Lookup is combinational, zero latency: hit = if_valid & entry valid & tag match.
REQ-021 pred_pc = stored target when hit and counter >= 2'b10, else if_pc+4; pred_taken set only in the former case.
REQ-022 When if_valid = 0: pred_pc = if_pc+4, pred_taken = 0.
REQ-023 Resolution is combinational: taken = ex_is_branch & ex_cond; next_PC = taken ? ex_src1+ex_src2 (mod 2^32) : ex_pc+4.
REQ-024 br_taken_cancel = ex_valid & ex_is_branch & (ex_pred_pc != next_PC); a non-branch never cancels.
REQ-025 Update on posedge clk when ex_valid & ex_is_branch & PRED_EN = 1; effect visible to lookup from next cycle.
REQ-026 Update, entry hits: counter +1 saturating at 2'b11 if taken, -1 saturating at 2'b00 if not; target rewritten with resolved target when taken.
REQ-027 Update, entry misses and taken: allocate (valid = 1, tag, target, counter = 2'b10), overwriting any occupant.
REQ-028 Update, entry misses and not taken: table unchanged.
REQ-029 Same-cycle lookup and update of the same index: lookup returns pre-update contents (no bypass).
REQ-030 mispred_cnt increments by 1 on each cycle br_taken_cancel = 1; wraps 32'hFFFFFFFF -> 0.
REQ-031 PRED_EN = 0: table registers are held in reset state; REQ-023/024/030 still apply.

Reset
REQ-032 While reset = 1: all valid bits 0, counters 2'b01, targets and tags 0, mispred_cnt 0; asynchronous, independent of clk.
REQ-033 While reset = 1: next_PC = 0, br_taken_cancel = 0, pred_taken = 0, pred_pc = if_pc+4; no table updates.
REQ-034 Reset asserted mid-update discards that update; first lookup after release misses.

Verification
REQ-035 After reset, if_pc = 0x1C000000 -> pred_pc = 0x1C000004, pred_taken = 0.
REQ-036 ex: pc 0x1C000010, b, src1 0x1C000010, src2 0x40, ex_pred_pc 0x1C000014 -> next_PC 0x1C000050, cancel 1, mispred_cnt 1; next cycle if_pc 0x1C000010 -> pred_pc 0x1C000050.
REQ-037 Same beq resolved not-taken twice after allocation -> counter 10 -> 01 -> 00; lookup then yields pc+4; third not-taken with ex_pred_pc = pc+4 -> cancel 0.
REQ-038 ENTRIES = 4: taken branches at 0x100 and 0x110 (same index) -> second evicts first; lookup 0x100 misses.
REQ-039 Same-cycle update and lookup of index 3 -> old prediction returned, new one the following cycle; reset pulse mid-test -> all outputs and mispred_cnt return to REQ-032/033 values immediately.
REQ-040 PRED_EN = 0: repeated taken branches -> pred_pc always if_pc+4, every taken branch cancels, mispred_cnt counts each.
